// File: rtl/riu_pkg.sv
// Shared encodings for the staged control unit: opcodes, ALU operations,
// writeback selects, CSR modes and the issue FSM state type.
package riu_pkg;

    // Instruction opcodes understood by the decoder
    localparam logic [6:0] OP_RTYPE   = 7'h33;
    localparam logic [6:0] OP_ITYPE   = 7'h13;
    localparam logic [6:0] OP_LUI     = 7'h37;
    localparam logic [6:0] OP_SYSTEM  = 7'h73;

    // funct7 qualifiers
    localparam logic [6:0] F7_BASE    = 7'h00;
    localparam logic [6:0] F7_ALT     = 7'h20;
    localparam logic [6:0] F7_MULDIV  = 7'h01;

    // ALU operation encodings
    localparam logic [3:0] ALU_AND    = 4'b0000;
    localparam logic [3:0] ALU_OR     = 4'b0001;
    localparam logic [3:0] ALU_XOR    = 4'b0010;
    localparam logic [3:0] ALU_ADD    = 4'b0011;
    localparam logic [3:0] ALU_SUB    = 4'b0100;
    localparam logic [3:0] ALU_MUL    = 4'b0101;
    localparam logic [3:0] ALU_MULH   = 4'b0110;
    localparam logic [3:0] ALU_MULHU  = 4'b0111;
    localparam logic [3:0] ALU_SLL    = 4'b1000;
    localparam logic [3:0] ALU_SRL    = 4'b1001;
    localparam logic [3:0] ALU_SRA    = 4'b1010;
    localparam logic [3:0] ALU_SLT    = 4'b1100;
    localparam logic [3:0] ALU_SLTU   = 4'b1101;

    // Writeback source selects
    localparam logic [1:0] REGSEL_GPIO = 2'b00;
    localparam logic [1:0] REGSEL_LUI  = 2'b01;
    localparam logic [1:0] REGSEL_ALU  = 2'b10;

    // CSR access modes
    localparam logic [1:0] CSR_NONE   = 2'b00;
    localparam logic [1:0] CSR_WRITE  = 2'b01;
    localparam logic [1:0] CSR_SET    = 2'b10;
    localparam logic [1:0] CSR_CLEAR  = 2'b11;

    // Issue FSM states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_MUL_WAIT = 2'd2
    } state_t;

    // Width of the GPIO input channel select; never narrower than one bit
    function automatic int rsel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/riu_decoder.sv
// Purely combinational instruction decode. Any unsupported encoding comes out
// as illegal with all side-effect enables cleared.
module riu_decoder
    import riu_pkg::*;
#(
    parameter int          NUM_GPIO    = 2,
    parameter logic [11:0] GPIO_BASE   = 12'hF00,
    parameter int          GPIO_STRIDE = 4,
    parameter int          RSEL_W      = 1
) (
    input  logic [6:0]          i_opcode,
    input  logic [2:0]          i_funct3,
    input  logic [6:0]          i_funct7,
    input  logic [11:0]         i_csr,
    output logic [3:0]          o_aluop,
    output logic                o_alusrc,
    output logic [1:0]          o_regsel,
    output logic                o_regwrite,
    output logic [NUM_GPIO-1:0] o_gpio_we,
    output logic [RSEL_W-1:0]   o_gpio_rsel,
    output logic [1:0]          o_csr_mode,
    output logic                o_illegal,
    output logic                o_is_mul
);

    logic w_illegal;
    logic w_hit;

    // Decode opcode/funct fields and the CSR address into control fields
    always_comb begin
        o_aluop     = ALU_AND;
        o_alusrc    = 1'b0;
        o_regsel    = REGSEL_ALU;
        o_regwrite  = 1'b0;
        o_gpio_we   = '0;
        o_gpio_rsel = '0;
        o_csr_mode  = CSR_NONE;
        o_illegal   = 1'b0;
        o_is_mul    = 1'b0;
        w_illegal   = 1'b0;
        w_hit       = 1'b0;

        case (i_opcode)
            OP_RTYPE: begin
                o_regwrite = 1'b1;
                case ({i_funct7, i_funct3})
                    {F7_BASE,   3'd0}: o_aluop = ALU_ADD;
                    {F7_BASE,   3'd1}: o_aluop = ALU_SLL;
                    {F7_BASE,   3'd2}: o_aluop = ALU_SLT;
                    {F7_BASE,   3'd3}: o_aluop = ALU_SLTU;
                    {F7_BASE,   3'd4}: o_aluop = ALU_XOR;
                    {F7_BASE,   3'd5}: o_aluop = ALU_SRL;
                    {F7_BASE,   3'd6}: o_aluop = ALU_OR;
                    {F7_BASE,   3'd7}: o_aluop = ALU_AND;
                    {F7_ALT,    3'd0}: o_aluop = ALU_SUB;
                    {F7_ALT,    3'd5}: o_aluop = ALU_SRA;
                    {F7_MULDIV, 3'd0}: begin o_aluop = ALU_MUL;   o_is_mul = 1'b1; end
                    {F7_MULDIV, 3'd1}: begin o_aluop = ALU_MULH;  o_is_mul = 1'b1; end
                    {F7_MULDIV, 3'd3}: begin o_aluop = ALU_MULHU; o_is_mul = 1'b1; end
                    default:           w_illegal = 1'b1;
                endcase
            end
            OP_ITYPE: begin
                o_regwrite = 1'b1;
                o_alusrc   = 1'b1;
                case (i_funct3)
                    3'd0: o_aluop = ALU_ADD;
                    3'd1: begin
                        // Shift-immediate only defined with a zero funct7
                        if (i_funct7 == F7_BASE) o_aluop = ALU_SLL;
                        else                     w_illegal = 1'b1;
                    end
                    3'd2: o_aluop = ALU_SLT;
                    3'd3: o_aluop = ALU_SLTU;
                    3'd4: o_aluop = ALU_XOR;
                    3'd5: begin
                        if (i_funct7 == F7_ALT)       o_aluop = ALU_SRA;
                        else if (i_funct7 == F7_BASE) o_aluop = ALU_SRL;
                        else                          w_illegal = 1'b1;
                    end
                    3'd6: o_aluop = ALU_OR;
                    default: o_aluop = ALU_AND;
                endcase
            end
            OP_LUI: begin
                o_regwrite = 1'b1;
                o_alusrc   = 1'b1;
                o_aluop    = ALU_ADD;
                o_regsel   = REGSEL_LUI;
            end
            OP_SYSTEM: begin
                case (i_funct3)
                    3'd1:    o_csr_mode = CSR_WRITE;
                    3'd2:    o_csr_mode = CSR_SET;
                    3'd3:    o_csr_mode = CSR_CLEAR;
                    default: w_illegal  = 1'b1;
                endcase
                // Channel k input sits at base+k*stride, output two above it
                for (int k = 0; k < NUM_GPIO; k++) begin
                    if (i_csr == 12'(int'(GPIO_BASE) + k * GPIO_STRIDE)) begin
                        w_hit       = 1'b1;
                        o_regwrite  = 1'b1;
                        o_regsel    = REGSEL_GPIO;
                        o_gpio_rsel = RSEL_W'(k);
                    end else if (i_csr == 12'(int'(GPIO_BASE) + k * GPIO_STRIDE + 2)) begin
                        w_hit        = 1'b1;
                        o_gpio_we[k] = 1'b1;
                    end
                end
                if (!w_hit) w_illegal = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase

        // An illegal encoding must not leave any write enable behind
        if (w_illegal) begin
            o_aluop     = ALU_AND;
            o_alusrc    = 1'b0;
            o_regsel    = REGSEL_ALU;
            o_regwrite  = 1'b0;
            o_gpio_we   = '0;
            o_gpio_rsel = '0;
            o_csr_mode  = CSR_NONE;
            o_is_mul    = 1'b0;
            o_illegal   = 1'b1;
        end
    end

endmodule

// File: rtl/staged_control_unit.sv
// Registered control unit: decodes one instruction per accept and presents
// the controls the following cycle; multiplies stall issue for MUL_LAT-1
// cycles and then present their controls. Handshake: an instruction is taken
// on a rising edge where in_valid and in_ready are both 1; out_valid marks the
// single cycle in which the registered controls are meaningful.
module staged_control_unit
    import riu_pkg::*;
#(
    parameter int          NUM_GPIO    = 2,
    parameter int          MUL_LAT     = 3,
    parameter logic [11:0] GPIO_BASE   = 12'hF00,
    parameter int          GPIO_STRIDE = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [6:0]                        opcode,
    input  logic [2:0]                        funct3,
    input  logic [6:0]                        funct7,
    input  logic [11:0]                       csr,
    output logic                              out_valid,
    output logic [3:0]                        aluop,
    output logic                              alusrc,
    output logic [1:0]                        regsel,
    output logic                              regwrite,
    output logic [NUM_GPIO-1:0]               gpio_we,
    output logic [rsel_width(NUM_GPIO)-1:0]   gpio_rsel,
    output logic [1:0]                        csr_mode,
    output logic                              illegal
);

    localparam int         RSEL_W   = rsel_width(NUM_GPIO);
    localparam bit         LONG_MUL = (MUL_LAT > 1);
    // Remaining wait cycles after the first MUL_WAIT cycle
    localparam logic [3:0] CNT_LOAD = (MUL_LAT > 1) ? 4'(MUL_LAT - 2) : 4'd0;

    logic [3:0]          w_aluop;
    logic                w_alusrc;
    logic [1:0]          w_regsel;
    logic                w_regwrite;
    logic [NUM_GPIO-1:0] w_gpio_we;
    logic [RSEL_W-1:0]   w_gpio_rsel;
    logic [1:0]          w_csr_mode;
    logic                w_illegal;
    logic                w_is_mul;
    logic                w_accept;
    logic                w_long_mul;
    logic                w_mul_done;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          r_mul_aluop;

    logic                r_out_valid;
    logic [3:0]          r_aluop;
    logic                r_alusrc;
    logic [1:0]          r_regsel;
    logic                r_regwrite;
    logic [NUM_GPIO-1:0] r_gpio_we;
    logic [RSEL_W-1:0]   r_gpio_rsel;
    logic [1:0]          r_csr_mode;
    logic                r_illegal;

    riu_decoder #(
        .NUM_GPIO    (NUM_GPIO),
        .GPIO_BASE   (GPIO_BASE),
        .GPIO_STRIDE (GPIO_STRIDE),
        .RSEL_W      (RSEL_W)
    ) u_decoder (
        .i_opcode    (opcode),
        .i_funct3    (funct3),
        .i_funct7    (funct7),
        .i_csr       (csr),
        .o_aluop     (w_aluop),
        .o_alusrc    (w_alusrc),
        .o_regsel    (w_regsel),
        .o_regwrite  (w_regwrite),
        .o_gpio_we   (w_gpio_we),
        .o_gpio_rsel (w_gpio_rsel),
        .o_csr_mode  (w_csr_mode),
        .o_illegal   (w_illegal),
        .o_is_mul    (w_is_mul)
    );

    // Ready is gated by reset so nothing is taken while the unit is held
    assign in_ready   = rst_n && (r_state != ST_MUL_WAIT);
    assign w_accept   = in_valid && in_ready;
    assign w_long_mul = w_is_mul && LONG_MUL;
    assign w_mul_done = (r_state == ST_MUL_WAIT) && (r_cnt == 4'd0);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_ISSUE: begin
                if (w_accept) w_state_nxt = w_long_mul ? ST_MUL_WAIT : ST_ISSUE;
                else          w_state_nxt = ST_IDLE;
            end
            ST_MUL_WAIT: begin
                if (r_cnt == 4'd0) w_state_nxt = ST_ISSUE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Multiply wait counter and the pending multiply's ALU operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= 4'd0;
            r_mul_aluop <= ALU_AND;
        end else if (w_accept && w_long_mul) begin
            r_cnt       <= CNT_LOAD;
            r_mul_aluop <= w_aluop;
        end else if ((r_state == ST_MUL_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt       <= r_cnt - 4'd1;
        end
    end

    // Output registers: load on issue or multiply completion, otherwise
    // drop valid and every write/side-effect enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_aluop     <= ALU_AND;
            r_alusrc    <= 1'b0;
            r_regsel    <= REGSEL_ALU;
            r_regwrite  <= 1'b0;
            r_gpio_we   <= '0;
            r_gpio_rsel <= '0;
            r_csr_mode  <= CSR_NONE;
            r_illegal   <= 1'b0;
        end else if (w_accept && !w_long_mul) begin
            r_out_valid <= 1'b1;
            r_aluop     <= w_aluop;
            r_alusrc    <= w_alusrc;
            r_regsel    <= w_regsel;
            r_regwrite  <= w_regwrite;
            r_gpio_we   <= w_gpio_we;
            r_gpio_rsel <= w_gpio_rsel;
            r_csr_mode  <= w_csr_mode;
            r_illegal   <= w_illegal;
        end else if (w_mul_done) begin
            r_out_valid <= 1'b1;
            r_aluop     <= r_mul_aluop;
            r_alusrc    <= 1'b0;
            r_regsel    <= REGSEL_ALU;
            r_regwrite  <= 1'b1;
            r_gpio_we   <= '0;
            r_gpio_rsel <= '0;
            r_csr_mode  <= CSR_NONE;
            r_illegal   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_regwrite  <= 1'b0;
            r_gpio_we   <= '0;
            r_csr_mode  <= CSR_NONE;
        end
    end

    assign out_valid = r_out_valid;
    assign aluop     = r_aluop;
    assign alusrc    = r_alusrc;
    assign regsel    = r_regsel;
    assign regwrite  = r_regwrite;
    assign gpio_we   = r_gpio_we;
    assign gpio_rsel = r_gpio_rsel;
    assign csr_mode  = r_csr_mode;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_staged_control_unit.sv
// Directed bench for staged_control_unit with default parameters
// (NUM_GPIO=2, MUL_LAT=3, GPIO_BASE=12'hF00, GPIO_STRIDE=4).
module tb_staged_control_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] csr;
    logic        out_valid;
    logic [3:0]  aluop;
    logic        alusrc;
    logic [1:0]  regsel;
    logic        regwrite;
    logic [1:0]  gpio_we;
    logic [0:0]  gpio_rsel;
    logic [1:0]  csr_mode;
    logic        illegal;

    int n_checks = 0;
    int n_errors = 0;

    staged_control_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7    (funct7),
        .csr       (csr),
        .out_valid (out_valid),
        .aluop     (aluop),
        .alusrc    (alusrc),
        .regsel    (regsel),
        .regwrite  (regwrite),
        .gpio_we   (gpio_we),
        .gpio_rsel (gpio_rsel),
        .csr_mode  (csr_mode),
        .illegal   (illegal)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_ctrl(input string tag, input logic ov, input logic [3:0] op,
                               input logic src, input logic [1:0] rs, input logic rw,
                               input logic [1:0] we, input logic sel,
                               input logic [1:0] md, input logic ill);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        check({tag, ".aluop"},     32'(aluop),     32'(op));
        check({tag, ".alusrc"},    32'(alusrc),    32'(src));
        check({tag, ".regsel"},    32'(regsel),    32'(rs));
        check({tag, ".regwrite"},  32'(regwrite),  32'(rw));
        check({tag, ".gpio_we"},   32'(gpio_we),   32'(we));
        check({tag, ".gpio_rsel"}, 32'(gpio_rsel), 32'(sel));
        check({tag, ".csr_mode"},  32'(csr_mode),  32'(md));
        check({tag, ".illegal"},   32'(illegal),   32'(ill));
    endtask

    // Present one instruction, let it be accepted on the next rising edge,
    // return 1 time unit after that edge with in_valid dropped.
    task automatic send(input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [11:0] c);
        opcode   = op;
        funct3   = f3;
        funct7   = f7;
        csr      = c;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        opcode   = 7'h00;
        funct3   = 3'd0;
        funct7   = 7'h00;
        csr      = 12'h000;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        expect_ctrl("rst", 1'b0, 4'b0000, 1'b0, 2'b10, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        check("rst.in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // back-to-back add then addi
        send(7'h33, 3'd0, 7'h00, 12'h000);
        expect_ctrl("add", 1'b1, 4'b0011, 1'b0, 2'b10, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0);
        send(7'h13, 3'd0, 7'h00, 12'h000);
        expect_ctrl("addi", 1'b1, 4'b0011, 1'b1, 2'b10, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0);
        @(posedge clk);
        #1;
        check("idle.out_valid", 32'(out_valid), 32'd0);
        check("idle.regwrite",  32'(regwrite),  32'd0);

        // assorted ALU decodes
        send(7'h33, 3'd0, 7'h20, 12'h000);
        check("sub.aluop", 32'(aluop), 32'h4);
        send(7'h33, 3'd3, 7'h00, 12'h000);
        check("sltu.aluop", 32'(aluop), 32'hd);
        send(7'h13, 3'd5, 7'h20, 12'h000);
        expect_ctrl("srai", 1'b1, 4'b1010, 1'b1, 2'b10, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0);
        send(7'h13, 3'd5, 7'h00, 12'h000);
        check("srli.aluop", 32'(aluop), 32'h9);
        send(7'h13, 3'd5, 7'h10, 12'h000);
        expect_ctrl("srx_bad", 1'b1, 4'b0000, 1'b0, 2'b10, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
        send(7'h13, 3'd7, 7'h00, 12'h000);
        check("andi.aluop",  32'(aluop),  32'h0);
        check("andi.alusrc", 32'(alusrc), 32'd1);
        send(7'h37, 3'd0, 7'h00, 12'h000);
        check("lui.regsel",   32'(regsel),   32'h1);
        check("lui.regwrite", 32'(regwrite), 32'd1);

        // multiply with 3-cycle latency
        send(7'h33, 3'd0, 7'h01, 12'h000);
        check("mul.c1.in_ready",  32'(in_ready),  32'd0);
        check("mul.c1.out_valid", 32'(out_valid), 32'd0);
        check("mul.c1.regwrite",  32'(regwrite),  32'd0);
        @(posedge clk);
        #1;
        check("mul.c2.in_ready",  32'(in_ready),  32'd0);
        check("mul.c2.out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        expect_ctrl("mul.c3", 1'b1, 4'b0101, 1'b0, 2'b10, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0);
        check("mul.c3.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check("mul.c4.out_valid", 32'(out_valid), 32'd0);

        // GPIO output and input channels
        send(7'h73, 3'd1, 7'h00, 12'hF06);
        expect_ctrl("gpo1", 1'b1, 4'b0000, 1'b0, 2'b10, 1'b0, 2'b10, 1'b0, 2'b01, 1'b0);
        send(7'h73, 3'd1, 7'h00, 12'hF04);
        expect_ctrl("gpi1", 1'b1, 4'b0000, 1'b0, 2'b00, 1'b1, 2'b00, 1'b1, 2'b01, 1'b0);

        // illegal CSR channel and opcode
        send(7'h73, 3'd1, 7'h00, 12'hF08);
        expect_ctrl("csr_bad", 1'b1, 4'b0000, 1'b0, 2'b10, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
        send(7'h7F, 3'd0, 7'h00, 12'h000);
        expect_ctrl("op_bad", 1'b1, 4'b0000, 1'b0, 2'b10, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1);

        // set / clear modes on output channel 0
        send(7'h73, 3'd2, 7'h00, 12'hF02);
        check("csrrs.mode", 32'(csr_mode), 32'h2);
        check("csrrs.we",   32'(gpio_we),  32'h1);
        send(7'h73, 3'd3, 7'h00, 12'hF02);
        check("csrrc.mode", 32'(csr_mode), 32'h3);
        check("csrrc.we",   32'(gpio_we),  32'h1);
        @(posedge clk);
        #1;
        check("post_csr.csr_mode", 32'(csr_mode), 32'h0);
        check("post_csr.gpio_we",  32'(gpio_we),  32'h0);

        // reset in the middle of a multiply wait
        send(7'h33, 3'd1, 7'h01, 12'h000);
        check("mulh.wait.in_ready", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        expect_ctrl("midrst", 1'b0, 4'b0000, 1'b0, 2'b10, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        check("midrst.in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst.rel.in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("midrst.after%0d.out_valid", i), 32'(out_valid), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/staged_control_unit.md
STAGED_CONTROL_UNIT -- requirements
Module: staged_control_unit

Interface
REQ-001 SHALL have parameter NUM_GPIO, default 2, number of GPIO CSR channels (1..8).
REQ-002 SHALL have parameter MUL_LAT, default 3, cycles from multiply accept to result (1..15).
REQ-003 SHALL have parameter GPIO_BASE, default 12'hF00, CSR address of channel 0 input.
REQ-004 SHALL have parameter GPIO_STRIDE, default 4, CSR address step between channels.
REQ-005 SHALL have ports in this order:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  block can accept.
- opcode  in  7  instruction opcode.
- funct3  in  3  instruction funct3.
- funct7  in  7  instruction funct7.
- csr  in  12  CSR address field.
- out_valid  out  1  decoded controls valid this cycle.
- aluop  out  4  ALU operation.
- alusrc  out  1  1 = immediate operand.
- regsel  out  2  writeback select: 00 GPIO, 01 LUI imm, 10 ALU.
- regwrite  out  1  register file write enable.
- gpio_we  out  NUM_GPIO  one-hot GPIO output write enable.
- gpio_rsel  out  $clog2(NUM_GPIO) or 1 if NUM_GPIO=1  GPIO input channel select.
- csr_mode  out  2  01 write, 10 set, 11 clear, 00 none.
- illegal  out  1  unsupported encoding.

Function
REQ-006 SHALL accept an instruction on any edge with in_valid=1 and in_ready=1.
REQ-007 SHALL register all decoded controls; non-multiply latency 1: out_valid=1 for exactly the cycle after accept.
REQ-008 SHALL decode R-type 0x33, I-type 0x13, LUI 0x37 to aluop/alusrc/regsel/regwrite with the standard team encoding: and 0000, or 0001, xor 0010, add 0011, sub 0100, mul 0101, mulh 0110, mulhu 0111, sll 1000, srl 1001, sra 1010, slt 1100, sltu 1101.
REQ-009 SHALL treat I-type funct3=5 as srai when funct7=0x20, srli when 0x00, illegal otherwise.
REQ-010 SHALL decode opcode 0x73 funct3 1/2/3 as csrrw/csrrs/csrrc, csr_mode 01/10/11.
REQ-011 SHALL map CSR GPIO_BASE+k*GPIO_STRIDE to input channel k: regwrite=1, regsel=00, gpio_rsel=k.
REQ-012 SHALL map CSR GPIO_BASE+k*GPIO_STRIDE+2 to output channel k: gpio_we[k]=1, regwrite=0.
REQ-013 SHALL flag illegal=1 with regwrite=0 and gpio_we=0 for any undefined opcode, funct3/funct7 pair, CSR address, or channel k>=NUM_GPIO; out_valid still pulses.
REQ-014 SHALL implement FSM IDLE, ISSUE, MUL_WAIT:
- IDLE -> ISSUE on accept of non-multiply.
- IDLE -> MUL_WAIT on accept of mul/mulh/mulhu when MUL_LAT>1; MUL_LAT=1 behaves as non-multiply.
- ISSUE -> ISSUE on back-to-back accept, else IDLE.
- MUL_WAIT counts down MUL_LAT-1 cycles, then -> ISSUE.
REQ-015 SHALL hold in_ready=0 throughout MUL_WAIT; in_ready=1 in IDLE and ISSUE.
REQ-016 SHALL assert out_valid and regwrite for a multiply exactly MUL_LAT cycles after accept, with out_valid=0 during MUL_WAIT.
REQ-017 SHALL drive regwrite, gpio_we, csr_mode to 0 whenever out_valid=0.

Reset
REQ-018 SHALL on rst_n=0 immediately force: FSM IDLE, counter 0, out_valid 0, aluop 0000, alusrc 0, regsel 10, regwrite 0, gpio_we 0, gpio_rsel 0, csr_mode 00, illegal 0.
REQ-019 SHALL abandon an in-flight multiply on reset mid-MUL_WAIT, emitting no out_valid.
REQ-020 SHALL hold in_ready=0 during reset and 1 on the first cycle after deassertion.

Structure
REQ-021 SHALL place aluop encodings, opcode constants, csr_mode encodings and the FSM state enum in shared package riu_pkg.
REQ-022 SHALL isolate combinational decode in sub-module riu_decoder; staged_control_unit holds FSM, counter and output registers.

Verification
REQ-023 Reset: rst_n=0 mid-MUL_WAIT -> all outputs at REQ-018 values same cycle; no out_valid after release.
REQ-024 Back-to-back: add (0x33,f3 0,f7 0) then addi (0x13,f3 0) -> out_valid two consecutive cycles, aluop 0011, alusrc 0 then 1.
REQ-025 Multiply, MUL_LAT=3: mul (0x33,f3 0,f7 0x01) -> in_ready 0 for 2 cycles, out_valid+regwrite+aluop 0101 at cycle 3.
REQ-026 GPIO, NUM_GPIO=2: csrrw csr 0xF06 -> gpio_we=2'b10, regwrite 0; csrrw 0xF04 -> gpio_rsel 1, regsel 00.
REQ-027 Illegal: csr 0xF08 with NUM_GPIO=2, and opcode 0x7F -> illegal 1, regwrite 0, gpio_we 0, out_valid 1.
REQ-028 Modes: funct3 2 and 3 on csr 0xF02 -> csr_mode 10 then 11, gpio_we[0]=1.
